// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// forward-select encodings, the load ResultSrc code and the shadow entry type.
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [7:0] WAIT_MAX = 8'd255;

    // Shadow copy of the destination-register bookkeeping for one stage.
    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       isload;
    } shadow_t;

    localparam shadow_t SHADOW_CLR = '{rd: 5'd0, regwrite: 1'b0, isload: 1'b0};

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forward selector: the Memory stage wins over Writeback, and x0 is
// never forwarded.
module fwd_select
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] m_rd,
    input  logic       m_regwrite,
    input  logic [4:0] w_rd,
    input  logic       w_regwrite,
    output logic [1:0] sel
);

    // Priority compare of the source register against the M and W shadows.
    always_comb begin
        sel = FWD_RF;
        if (m_regwrite && (m_rd != 5'd0) && (m_rd == rs)) begin
            sel = FWD_MEM;
        end else if (w_regwrite && (w_rd != 5'd0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and memory-wait stalls, branch
// flushes, operand forwarding and a sticky data-memory timeout.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [4:0] i_Rs1D,
    input  logic [4:0] i_Rs2D,
    input  logic [4:0] i_RdD,
    input  logic       i_RegWriteD,
    input  logic [1:0] i_ResultSrcD,
    input  logic [4:0] i_Rs1E,
    input  logic [4:0] i_Rs2E,
    input  logic       i_PCSrcE,
    input  logic       i_MemReqM,
    input  logic       i_MemReadyM,
    output logic       o_StallF,
    output logic       o_StallD,
    output logic       o_StallE,
    output logic       o_StallM,
    output logic       o_FlushD,
    output logic       o_FlushE,
    output logic       o_FlushW,
    output logic [1:0] o_ForwardAE,
    output logic [1:0] o_ForwardBE,
    output logic       o_MemTimeout
);

    shadow_t    e_r, m_r, w_r;
    shadow_t    decode_s;
    state_t     state_r, state_nx_s;
    logic [7:0] wait_cnt_r, wait_cnt_nx_s;
    logic       timeout_r, timeout_nx_s;
    logic       mem_stall_s, lw_stall_s, flush_e_s;
    logic [1:0] fwd_a_s, fwd_b_s;
    logic       unused_isload_s;

    // The load flag only matters in E; later copies exist for bookkeeping.
    assign unused_isload_s = m_r.isload ^ w_r.isload;

    // Raw hazard conditions derived from the shadows and this cycle's inputs.
    always_comb begin
        mem_stall_s     = i_MemReqM & ~i_MemReadyM;
        lw_stall_s      = e_r.isload & (e_r.rd != 5'd0) &
                          ((e_r.rd == i_Rs1D) | (e_r.rd == i_Rs2D));
        flush_e_s       = (lw_stall_s | i_PCSrcE) & ~mem_stall_s;
        decode_s.rd       = i_RdD;
        decode_s.regwrite = i_RegWriteD;
        decode_s.isload   = (i_ResultSrcD == RESULT_LOAD);
    end

    fwd_select u_fwd_a (
        .rs         (i_Rs1E),
        .m_rd       (m_r.rd),
        .m_regwrite (m_r.regwrite),
        .w_rd       (w_r.rd),
        .w_regwrite (w_r.regwrite),
        .sel        (fwd_a_s)
    );

    fwd_select u_fwd_b (
        .rs         (i_Rs2E),
        .m_rd       (m_r.rd),
        .m_regwrite (m_r.regwrite),
        .w_rd       (w_r.rd),
        .w_regwrite (w_r.regwrite),
        .sel        (fwd_b_s)
    );

    // Shadow pipeline: flush clears win over loads, a memory stall freezes E and M.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            e_r <= SHADOW_CLR;
            m_r <= SHADOW_CLR;
            w_r <= SHADOW_CLR;
        end else begin
            if (flush_e_s) begin
                e_r <= SHADOW_CLR;
            end else if (!mem_stall_s) begin
                e_r <= decode_s;
            end else begin
                e_r <= e_r;
            end
            if (!mem_stall_s) begin
                m_r <= e_r;
            end else begin
                m_r <= m_r;
            end
            if (mem_stall_s) begin
                w_r <= SHADOW_CLR;
            end else begin
                w_r <= m_r;
            end
        end
    end

    // Memory-wait FSM next state, saturating wait counter and sticky timeout.
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_nx_s    = ST_WAIT;
                    wait_cnt_nx_s = 8'd0;
                end else begin
                    state_nx_s    = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (i_MemReadyM) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_WAIT;
                end
                if (wait_cnt_r != WAIT_MAX) begin
                    wait_cnt_nx_s = wait_cnt_r + 8'd1;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r;
                end
            end
            default: begin
                state_nx_s    = ST_RUN;
                wait_cnt_nx_s = 8'd0;
            end
        endcase
        timeout_nx_s = timeout_r | (wait_cnt_nx_s == WAIT_MAX);
    end

    // FSM, counter and timeout registers.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
            timeout_r  <= timeout_nx_s;
        end
    end

    // Output decode; everything is forced quiet while reset is asserted.
    always_comb begin
        o_StallF     = 1'b0;
        o_StallD     = 1'b0;
        o_StallE     = 1'b0;
        o_StallM     = 1'b0;
        o_FlushD     = 1'b0;
        o_FlushE     = 1'b0;
        o_FlushW     = 1'b0;
        o_ForwardAE  = FWD_RF;
        o_ForwardBE  = FWD_RF;
        o_MemTimeout = timeout_r;
        if (i_Reset) begin
            o_StallF    = lw_stall_s | mem_stall_s;
            o_StallD    = lw_stall_s | mem_stall_s;
            o_StallE    = mem_stall_s;
            o_StallM    = mem_stall_s;
            o_FlushD    = i_PCSrcE & ~mem_stall_s;
            o_FlushE    = flush_e_s;
            o_FlushW    = mem_stall_s;
            o_ForwardAE = fwd_a_s;
            o_ForwardBE = fwd_b_s;
        end else begin
            o_StallF    = 1'b0;
            o_ForwardAE = FWD_RF;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors are queued when
// stimulus is applied and compared once the combinational outputs settle.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [4:0] i_Rs1D, i_Rs2D, i_RdD, i_Rs1E, i_Rs2E;
    logic       i_RegWriteD, i_PCSrcE, i_MemReqM, i_MemReadyM;
    logic [1:0] i_ResultSrcD;
    logic       o_StallF, o_StallD, o_StallE, o_StallM;
    logic       o_FlushD, o_FlushE, o_FlushW, o_MemTimeout;
    logic [1:0] o_ForwardAE, o_ForwardBE;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    hazard_ctrl dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Rs1D       (i_Rs1D),
        .i_Rs2D       (i_Rs2D),
        .i_RdD        (i_RdD),
        .i_RegWriteD  (i_RegWriteD),
        .i_ResultSrcD (i_ResultSrcD),
        .i_Rs1E       (i_Rs1E),
        .i_Rs2E       (i_Rs2E),
        .i_PCSrcE     (i_PCSrcE),
        .i_MemReqM    (i_MemReqM),
        .i_MemReadyM  (i_MemReadyM),
        .o_StallF     (o_StallF),
        .o_StallD     (o_StallD),
        .o_StallE     (o_StallE),
        .o_StallM     (o_StallM),
        .o_FlushD     (o_FlushD),
        .o_FlushE     (o_FlushE),
        .o_FlushW     (o_FlushW),
        .o_ForwardAE  (o_ForwardAE),
        .o_ForwardBE  (o_ForwardBE),
        .o_MemTimeout (o_MemTimeout)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vector {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB,Timeout}.
    function automatic logic [11:0] ov(input logic sfd, input logic sem, input logic fd,
                                       input logic fe, input logic fw, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic to);
        return {sfd, sfd, sem, sem, fd, fe, fw, fa, fb, to};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {o_StallF, o_StallD, o_StallE, o_StallM, o_FlushD, o_FlushE, o_FlushW,
                o_ForwardAE, o_ForwardBE, o_MemTimeout};
    endfunction

    // Called just after a falling edge with inputs applied; ends on the next falling edge.
    task automatic cycle(input string tag, input logic [11:0] exp);
        sb_entry_t e;
        sb_q.push_back('{tag: tag, exp: exp});
        #2;
        e = sb_q.pop_front();
        check_val(e.tag, {20'd0, obs_vec()}, {20'd0, e.exp});
        @(negedge i_Clk);
    endtask

    task automatic idle_inputs();
        i_Rs1D = 5'd0; i_Rs2D = 5'd0; i_RdD = 5'd0; i_Rs1E = 5'd0; i_Rs2E = 5'd0;
        i_RegWriteD = 1'b0; i_ResultSrcD = 2'b00; i_PCSrcE = 1'b0;
        i_MemReqM = 1'b0; i_MemReadyM = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_Reset = 1'b0;
        cycle("rst_hold", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
        i_Reset = 1'b1;
    endtask

    localparam logic [11:0] Z = 12'd0;
    localparam logic [11:0] MEMSTALL = 12'b1111_0010_0000;

    initial begin
        idle_inputs();
        i_Reset = 1'b0;
        @(negedge i_Clk);
        cycle("reset_out", Z);
        check_val("reset_state", 32'(dut.state_r), 32'(ST_RUN));
        check_val("reset_cnt", 32'(dut.wait_cnt_r), 32'd0);
        i_Reset = 1'b1;

        // Load-use hazards on Rs1 and Rs2, x0 and non-load destinations.
        i_RdD = 5'd5; i_RegWriteD = 1'b1; i_ResultSrcD = 2'b01;
        cycle("lu_load", Z);
        i_RdD = 5'd0; i_RegWriteD = 1'b0; i_ResultSrcD = 2'b00; i_Rs1D = 5'd5;
        cycle("lu_stall_rs1", ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
        cycle("lu_release", Z);
        i_RdD = 5'd7; i_RegWriteD = 1'b1; i_ResultSrcD = 2'b01; i_Rs1D = 5'd0;
        cycle("lu2_load", Z);
        i_RdD = 5'd0; i_RegWriteD = 1'b0; i_ResultSrcD = 2'b00; i_Rs2D = 5'd7;
        cycle("lu_stall_rs2", ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
        i_Rs2D = 5'd0; i_RegWriteD = 1'b1; i_ResultSrcD = 2'b01;
        cycle("lu_x0_load", Z);
        i_RegWriteD = 1'b0; i_ResultSrcD = 2'b00;
        cycle("lu_x0", Z);
        i_RdD = 5'd9; i_RegWriteD = 1'b1;
        cycle("alu_load", Z);
        i_RdD = 5'd0; i_RegWriteD = 1'b0; i_Rs1D = 5'd9;
        cycle("alu_no_stall", Z);

        // Forwarding priority and x0 suppression.
        do_reset();
        i_RdD = 5'd3; i_RegWriteD = 1'b1; i_Rs1E = 5'd3;
        cycle("fwd_empty", Z);
        cycle("fwd_fill", Z);
        i_RdD = 5'd0; i_RegWriteD = 1'b0;
        cycle("fwd_mem", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));
        i_Rs2E = 5'd3;
        cycle("fwd_mem_prio", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0));
        i_Rs2E = 5'd0;
        cycle("fwd_wb", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0));
        cycle("fwd_none", Z);

        // Branch flush, then the same branch while memory stalls.
        do_reset();
        i_PCSrcE = 1'b1;
        cycle("br_flush", ov(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0));
        i_MemReqM = 1'b1;
        cycle("br_memstall", MEMSTALL);
        check_val("br_state_wait", 32'(dut.state_r), 32'(ST_WAIT));
        i_PCSrcE = 1'b0; i_MemReadyM = 1'b1;
        cycle("br_ready", Z);

        // Three-cycle memory wait; E must be held so it reaches M afterwards.
        do_reset();
        i_RdD = 5'd4; i_RegWriteD = 1'b1;
        cycle("mw_load", Z);
        i_RdD = 5'd0; i_RegWriteD = 1'b0; i_MemReqM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle("mw_stall", MEMSTALL);
        end
        check_val("mw_state_wait", 32'(dut.state_r), 32'(ST_WAIT));
        i_MemReadyM = 1'b1;
        cycle("mw_ready", Z);
        check_val("mw_state_run", 32'(dut.state_r), 32'(ST_RUN));
        i_MemReqM = 1'b0; i_MemReadyM = 1'b0; i_Rs1E = 5'd4;
        cycle("mw_held_e", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0));

        // Timeout after a 300-cycle wait; sticky until reset.
        do_reset();
        i_MemReqM = 1'b1;
        for (int k = 0; k < 300; k++) begin
            cycle($sformatf("tmo_wait_%0d", k),
                  MEMSTALL | {11'd0, (k >= 256) ? 1'b1 : 1'b0});
        end
        check_val("tmo_cnt_sat", 32'(dut.wait_cnt_r), 32'd255);
        i_MemReadyM = 1'b1;
        cycle("tmo_ready", 12'd1);
        i_MemReqM = 1'b0; i_MemReadyM = 1'b0;
        cycle("tmo_sticky", 12'd1);
        i_Reset = 1'b0;
        #1;
        check_val("tmo_reset", 32'(o_MemTimeout), 32'd0);
        @(negedge i_Clk);
        i_Reset = 1'b1;

        // Reset asserted in the middle of a memory wait.
        idle_inputs();
        i_MemReqM = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle("rm_stall", MEMSTALL);
        end
        i_Reset = 1'b0;
        #1;
        check_val("rm_state", 32'(dut.state_r), 32'(ST_RUN));
        check_val("rm_cnt", 32'(dut.wait_cnt_r), 32'd0);
        cycle("rm_outputs", Z);
        idle_inputs();
        i_Reset = 1'b1;
        cycle("rm_after", Z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: i_Clk  in  1  pipeline clock, rising edge.
REQ-002 SHALL have: i_Reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: i_Rs1D, i_Rs2D, i_RdD  in  5 each  Decode-stage source and destination register numbers.
REQ-004 SHALL have: i_RegWriteD  in  1; i_ResultSrcD  in  2  Decode control (ResultSrc 2'b01 = load).
REQ-005 SHALL have: i_Rs1E, i_Rs2E  in  5 each  Execute-stage source register numbers from the datapath register.
REQ-006 SHALL have: i_PCSrcE  in  1  taken branch or jump resolved in Execute.
REQ-007 SHALL have: i_MemReqM  in  1  load/store in Memory; i_MemReadyM  in  1  data memory completes this cycle.
REQ-008 SHALL have: o_StallF, o_StallD, o_StallE, o_StallM  out  1 each  hold the stage register.
REQ-009 SHALL have: o_FlushD, o_FlushE, o_FlushW  out  1 each  load a bubble into the stage register.
REQ-010 SHALL have: o_ForwardAE, o_ForwardBE  out  2 each  00 regfile, 01 Writeback result, 10 Memory ALU result.
REQ-011 SHALL have: o_MemTimeout  out  1  sticky; data memory wait reached 255 cycles.

Function
REQ-012 SHALL keep internal shadow entries E, M, W, each holding {rd[4:0], regwrite, isload}.
- E loads {i_RdD, i_RegWriteD, i_ResultSrcD==2'b01} when not stalled.
- M loads from E, and W loads from M.
REQ-013 SHALL clear shadow E when o_FlushE=1, and clear shadow W when o_FlushW=1; a clear takes precedence over a load.
REQ-014 SHALL hold shadow E and shadow M unchanged while memStall=1.
REQ-015 SHALL compute memStall = i_MemReqM & ~i_MemReadyM, combinationally in the same cycle.
REQ-016 SHALL compute lwStall = E.isload & (E.rd != 0) & (E.rd == i_Rs1D | E.rd == i_Rs2D).
REQ-017 SHALL drive o_StallF = o_StallD = lwStall | memStall, and o_StallE = o_StallM = memStall.
REQ-018 SHALL drive o_FlushD = i_PCSrcE & ~memStall, and o_FlushE = (lwStall | i_PCSrcE) & ~memStall.
REQ-019 SHALL drive o_FlushW = memStall.
REQ-020 SHALL set o_ForwardAE as follows, in priority order:
- 10 if M.regwrite & M.rd != 0 & M.rd == i_Rs1E;
- otherwise 01 if W.regwrite & W.rd != 0 & W.rd == i_Rs1E;
- otherwise 00.
REQ-021 SHALL derive o_ForwardBE identically to REQ-020, using i_Rs2E.
REQ-022 SHALL run an FSM with states RUN and WAIT:
- RUN -> WAIT when memStall=1;
- WAIT -> RUN when i_MemReadyM=1;
- otherwise hold state.
REQ-023 SHALL clear the 8-bit wait counter on entering WAIT, and increment it each WAIT cycle, saturating at 255.
REQ-024 SHALL set o_MemTimeout when the counter reaches 255; it stays 1 until reset.
REQ-025 SHALL drive all outputs combinationally from the shadow state and inputs, except the FSM state, counter and o_MemTimeout, which are registered.
REQ-026 SHALL suppress forwarding and stall for register x0 in every case.

Reset
REQ-027 SHALL, on i_Reset=0 asynchronously, clear all shadow entries, put the FSM in RUN, set the counter to 0 and o_MemTimeout to 0.
REQ-028 SHALL, while reset is held, drive all stall, flush and forward outputs to 0 with no inputs active.
REQ-029 SHALL act on the first rising edge after reset deassertion with no extra delay.

Structure
REQ-030 SHALL place the FSM state enum, the forward-select encodings (FWD_RF/FWD_WB/FWD_MEM) and RESULT_LOAD=2'b01 in the shared pipeline package.
REQ-031 SHALL implement the forwarding comparator as sub-module fwd_select, instantiated twice (A and B).

Verification
REQ-032 Load-use: shadow E = {rd=5, isload=1}, i_Rs1D=5 -> o_StallF=o_StallD=o_FlushE=1 for one cycle, then 0.
REQ-033 Forwarding: M={rd=3, regwrite=1}, W={rd=3, regwrite=1}, i_Rs1E=3 -> o_ForwardAE=10; with M.rd=0 -> 01; with i_Rs1E=0 -> 00.
REQ-034 Branch: i_PCSrcE=1, no memStall -> o_FlushD=o_FlushE=1, stalls 0; the same cycle with memStall=1 -> flushes 0, all stalls 1, o_FlushW=1.
REQ-035 Memory wait: i_MemReqM=1, i_MemReadyM=0 for 3 cycles, then ready -> stalls 1 for 3 cycles, FSM WAIT then RUN, o_MemTimeout stays 0.
REQ-036 Timeout: i_MemReadyM held 0 for 300 cycles -> o_MemTimeout rises once the counter reaches 255, stays 1 after ready, and clears only on i_Reset=0.
REQ-037 Reset mid-WAIT: assert i_Reset=0 during a memory wait -> all outputs 0 immediately, FSM RUN, counter 0.
